// File: rtl/srm_isa_pkg.sv
// srm_isa_pkg: Simple RISC Machine ISA field positions, opcode/op codes, decode FSM states and read-count classification
package srm_isa_pkg;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RM = 3'b001;
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, PRESENT} state_t;
  function automatic logic [1:0] read_count(input logic [15:0] i);
    logic [2:0] c;
    logic [1:0] o;
    c = i[OPC_LSB+:3];
    o = i[OP_LSB+:2];
    return c == OPC_MOV ? (o == OP_MOVR ? 2'd1 : 2'd0) :
           c == OPC_ALU ? (o == OP_MVN ? 2'd1 : 2'd2) : 2'd0;
  endfunction
  function automatic logic is_legal(input logic [15:0] i);
    logic [1:0] o;
    o = i[OP_LSB+:2];
    return i[OPC_LSB+:3] == OPC_ALU || (i[OPC_LSB+:3] == OPC_MOV && (o == OP_MOVI || o == OP_MOVR));
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry FIFO (push/pop/din -> dout head, count); a pop frees a slot for a same-cycle push when full
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_pop = i_pop && r_count != '0;
  assign w_push = i_push && (r_count != (AW+1)'(DEPTH) || w_pop);
  assign o_dout = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: FIFO-buffered SRM decoder (in_valid/in_instr/in_ready in; rd_en/readnum/nsel reads; out_valid/out_ready decoded bundle out)
module instr_decode_stage
  import srm_isa_pkg::*;
#(
  parameter int DW = 16,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [15:0]            in_instr,
  output logic                   in_ready,
  output logic                   rd_en,
  output logic [2:0]             readnum,
  output logic [2:0]             nsel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             opcode,
  output logic [1:0]             op,
  output logic [1:0]             ALUop,
  output logic [1:0]             shift,
  output logic [2:0]             writenum,
  output logic [DW-1:0]          sximm5,
  output logic [DW-1:0]          sximm8,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t r_state, w_state;
  logic [15:0] r_ir, w_ir, w_head;
  logic [CW-1:0] w_count;
  logic w_take, w_pop, w_rd;
  logic r_illegal, r_rd_en, r_out_valid;
  logic [2:0] r_nsel, r_readnum, w_nsel;
  assign w_take = r_state == IDLE || (r_state == PRESENT && out_ready);
  assign w_pop = w_take && w_count != '0;
  assign in_ready = w_count != CW'(DEPTH);
  assign fifo_count = w_count;
  sync_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid && in_ready),
    .i_pop   (w_pop),
    .i_din   (in_instr),
    .o_dout  (w_head),
    .o_count (w_count)
  );
  always_comb begin
    w_ir = w_pop ? w_head : r_ir;
    w_state = r_state;
    case (r_state)
      RD_A:    w_state = read_count(r_ir) == 2'd2 ? RD_B : PRESENT;
      RD_B:    w_state = PRESENT;
      default: if (w_take) w_state = !w_pop ? IDLE : read_count(w_head) == 2'd0 ? PRESENT : RD_A;
    endcase
    w_rd = w_state == RD_A || w_state == RD_B;
    w_nsel = !w_rd ? 3'b000 : (w_state == RD_A && read_count(w_ir) == 2'd2) ? NSEL_RN : NSEL_RM;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_ir <= '0;
      r_illegal <= 1'b0;
      r_rd_en <= 1'b0;
      r_out_valid <= 1'b0;
      r_nsel <= '0;
      r_readnum <= '0;
    end else begin
      r_state <= w_state;
      r_ir <= w_ir;
      if (w_pop) r_illegal <= !is_legal(w_head);
      r_rd_en <= w_rd;
      r_out_valid <= w_state == PRESENT;
      r_nsel <= w_nsel;
      r_readnum <= w_nsel == NSEL_RN ? w_ir[RN_LSB+:3] : w_nsel == NSEL_RM ? w_ir[RM_LSB+:3] : 3'b000;
    end
  assign rd_en = r_rd_en;
  assign nsel = r_nsel;
  assign readnum = r_readnum;
  assign out_valid = r_out_valid;
  assign illegal = r_illegal;
  assign opcode = r_ir[OPC_LSB+:3];
  assign op = r_ir[OP_LSB+:2];
  assign ALUop = r_ir[OP_LSB+:2];
  assign shift = r_ir[SH_LSB+:2];
  assign writenum = (opcode == OPC_MOV && op == OP_MOVI) ? r_ir[RN_LSB+:3] : r_ir[RD_LSB+:3];
  assign sximm5 = {{(DW-5){r_ir[4]}}, r_ir[4:0]};
  assign sximm8 = {{(DW-8){r_ir[7]}}, r_ir[7:0]};
endmodule
